// File: rtl/plic_core_param.sv
`default_nettype none
// ============================================================================
// Module      : plic_core_param
// Description : Parametrised platform-level interrupt controller core.
//               Each of NUM_SRC sources passes through a gateway (level or
//               rising-edge) that latches a pending bit and blocks re-firing
//               while the source is pending or claimed (in service).
//               Eligible sources are arbitrated by a priority comparator
//               tree (highest priority wins, ties to the lowest ID). The
//               winner and the CPU request are registered. A claim/complete
//               handshake moves sources into and out of service.
//
//               Source k (bit k of every per-source vector) is ID k+1;
//               ID 0 means "no source". Requires 2**ID_W > NUM_SRC.
//
// Optional    : `define PLIC_EDGE_QUEUE_EN adds a 2-bit saturating counter
//               per edge-mode source that remembers edges which arrive while
//               the source is pending or in service and replays them once
//               the source is idle again. Undefined: such edges are lost.
//
// Ports       : i_clk          clock
//               i_rst_n        asynchronous active-low reset
//               i_interrupt    raw source lines (synchronous to i_clk)
//               i_src_en       per-source enable (gates eligibility only)
//               i_edge_mode    1 = rising-edge source, 0 = level source
//               i_pri          packed priorities, source k at [k*PRI_W +: PRI_W]
//               i_threshold    request raised only if winner priority > this
//               i_global_en    master enable for o_irq
//               i_claim        single-cycle claim strobe
//               i_complete     single-cycle complete strobe
//               i_complete_id  ID being completed
//               o_irq          registered interrupt request
//               o_max_id       registered winning ID (0 if none)
//               o_claim_id     ID returned by the most recent claim
//               o_pending      pending bits
//               o_in_service   claimed-but-not-completed bits
//
// Revision    : 1.0 - initial release
// ============================================================================
module plic_core_param #(
   parameter int NUM_SRC = 8,
   parameter int PRI_W   = 4,
   parameter int ID_W    = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [NUM_SRC-1:0]       i_interrupt,
   input  logic [NUM_SRC-1:0]       i_src_en,
   input  logic [NUM_SRC-1:0]       i_edge_mode,
   input  logic [NUM_SRC*PRI_W-1:0] i_pri,
   input  logic [PRI_W-1:0]         i_threshold,
   input  logic                     i_global_en,
   input  logic                     i_claim,
   input  logic                     i_complete,
   input  logic [ID_W-1:0]          i_complete_id,
   output logic                     o_irq,
   output logic [ID_W-1:0]          o_max_id,
   output logic [ID_W-1:0]          o_claim_id,
   output logic [NUM_SRC-1:0]       o_pending,
   output logic [NUM_SRC-1:0]       o_in_service
);

   // Arbitration tree geometry: leaves padded up to a power of two.
   localparam int c_levels = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int c_leaves = 1 << c_levels;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_in_service;
   logic [NUM_SRC-1:0] r_prev;
   logic               r_irq;
   logic [ID_W-1:0]    r_max_id;
   logic [ID_W-1:0]    r_claim_id;

   // ------------------------------------------------------------------------
   // Combinational
   // ------------------------------------------------------------------------
   logic               w_claim_hit;
   logic [NUM_SRC-1:0] w_claim_vec;
   logic [NUM_SRC-1:0] w_comp_vec;
   logic [NUM_SRC-1:0] w_edge;
   logic [NUM_SRC-1:0] w_req;
   logic [NUM_SRC-1:0] w_queue_set;
   logic [NUM_SRC-1:0] w_pending_set;
   logic [NUM_SRC-1:0] w_eligible;
   logic [NUM_SRC-1:0] w_pending_nxt;
   logic [NUM_SRC-1:0] w_in_service_nxt;
   logic [PRI_W-1:0]   w_win_pri;
   logic [ID_W-1:0]    w_win_id;

   // A claim only takes effect when a request is actually being presented;
   // it always acts on the registered winner.
   assign w_claim_hit = i_claim && r_irq;

   // ------------------------------------------------------------------------
   // Per-source gateway
   // ------------------------------------------------------------------------
   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      assign w_claim_vec[k] = w_claim_hit && (r_max_id == ID_W'(k + 1));

      // Out-of-range or not-in-service completes match no source and are
      // therefore ignored.
      assign w_comp_vec[k]  = i_complete && (i_complete_id == ID_W'(k + 1))
                              && r_in_service[k];

      assign w_edge[k] = i_interrupt[k] && !r_prev[k];
      assign w_req[k]  = i_edge_mode[k] ? w_edge[k] : i_interrupt[k];

`ifdef PLIC_EDGE_QUEUE_EN
      logic [1:0] r_cnt;
      logic       w_inc;
      logic       w_dec;

      // Dropped edge: arrives while the gateway is busy.
      assign w_inc = i_edge_mode[k] && w_edge[k]
                     && (r_pending[k] || r_in_service[k]);
      // Replay a queued edge once the gateway is idle.
      assign w_dec = i_edge_mode[k] && !r_pending[k] && !r_in_service[k]
                     && (r_cnt != 2'd0);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_cnt <= 2'd0;
         end else if (w_inc && !w_dec) begin
            if (r_cnt != 2'd3) begin
               r_cnt <= r_cnt + 2'd1;
            end
         end else if (w_dec && !w_inc) begin
            r_cnt <= r_cnt - 2'd1;
         end
      end

      assign w_queue_set[k] = w_dec;
`else
      assign w_queue_set[k] = 1'b0;
`endif

      // A busy gateway (pending or in service) drops new requests; this
      // also blocks a same-cycle re-set of the source being claimed.
      assign w_pending_set[k] = (w_req[k] && !r_pending[k] && !r_in_service[k])
                                || w_queue_set[k];

      // The source being claimed this cycle is excluded so that the
      // registered winner after a claim already reflects it; back-to-back
      // claims therefore never return the same ID.
      assign w_eligible[k] = r_pending[k] && i_src_en[k] && !r_in_service[k]
                             && !w_claim_vec[k]
                             && (i_pri[k*PRI_W +: PRI_W] != '0);
   end

   assign w_pending_nxt    = (r_pending & ~w_claim_vec) | w_pending_set;
   assign w_in_service_nxt = (r_in_service | w_claim_vec) & ~w_comp_vec;

   // ------------------------------------------------------------------------
   // Priority comparator tree. Ineligible leaves carry priority 0 and ID 0.
   // Pairs are reduced in place, left (lower ID) winning ties, so a node
   // whose priority is 0 also carries ID 0.
   // ------------------------------------------------------------------------
   always_comb begin
      logic [PRI_W-1:0] v_pri [c_leaves];
      logic [ID_W-1:0]  v_id  [c_leaves];

      for (int j = 0; j < c_leaves; j++) begin
         v_pri[j] = '0;
         v_id[j]  = '0;
      end
      for (int j = 0; j < NUM_SRC; j++) begin
         if (w_eligible[j]) begin
            v_pri[j] = i_pri[j*PRI_W +: PRI_W];
            v_id[j]  = ID_W'(j + 1);
         end
      end
      for (int l = c_levels - 1; l >= 0; l--) begin
         for (int n = 0; n < (1 << l); n++) begin
            if (v_pri[2*n+1] > v_pri[2*n]) begin
               v_pri[n] = v_pri[2*n+1];
               v_id[n]  = v_id[2*n+1];
            end else begin
               v_pri[n] = v_pri[2*n];
               v_id[n]  = v_id[2*n];
            end
         end
      end
      w_win_pri = v_pri[0];
      w_win_id  = v_id[0];
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pending    <= '0;
         r_in_service <= '0;
         r_prev       <= '0;
         r_irq        <= 1'b0;
         r_max_id     <= '0;
         r_claim_id   <= '0;
      end else begin
         r_prev       <= i_interrupt;
         r_pending    <= w_pending_nxt;
         r_in_service <= w_in_service_nxt;
         r_max_id     <= w_win_id;
         r_irq        <= i_global_en && (w_win_pri > i_threshold);
         if (i_claim) begin
            r_claim_id <= w_claim_hit ? r_max_id : '0;
         end
      end
   end

   assign o_irq        = r_irq;
   assign o_max_id     = r_max_id;
   assign o_claim_id   = r_claim_id;
   assign o_pending    = r_pending;
   assign o_in_service = r_in_service;

endmodule
`default_nettype wire

// File: tb/tb_plic_core_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_plic_core_param
// Description : Scoreboard testbench for plic_core_param. The stimulus
//               process steps a behavioural reference model once per cycle
//               and queues the outputs expected after the next clock edge;
//               a monitor process compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_plic_core_param;

   localparam int NUM_SRC = 8;
   localparam int PRI_W   = 4;
   localparam int ID_W    = 4;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_SRC-1:0]       interrupt;
   logic [NUM_SRC-1:0]       src_en;
   logic [NUM_SRC-1:0]       edge_mode;
   logic [NUM_SRC*PRI_W-1:0] pri;
   logic [PRI_W-1:0]         threshold;
   logic                     global_en;
   logic                     claim;
   logic                     complete;
   logic [ID_W-1:0]          complete_id;
   logic                     irq;
   logic [ID_W-1:0]          max_id;
   logic [ID_W-1:0]          claim_id;
   logic [NUM_SRC-1:0]       pending;
   logic [NUM_SRC-1:0]       in_service;

   plic_core_param #(.NUM_SRC(NUM_SRC), .PRI_W(PRI_W), .ID_W(ID_W)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_interrupt  (interrupt),
      .i_src_en     (src_en),
      .i_edge_mode  (edge_mode),
      .i_pri        (pri),
      .i_threshold  (threshold),
      .i_global_en  (global_en),
      .i_claim      (claim),
      .i_complete   (complete),
      .i_complete_id(complete_id),
      .o_irq        (irq),
      .o_max_id     (max_id),
      .o_claim_id   (claim_id),
      .o_pending    (pending),
      .o_in_service (in_service)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d required %0d", nm, act, exp);
   endtask

   // ------------------------------------------------------------------------
   // Reference model: interrupt controller state as plain arrays/integers.
   // ------------------------------------------------------------------------
   bit m_pend [NUM_SRC];
   bit m_svc  [NUM_SRC];
   bit m_prev [NUM_SRC];
   int m_cnt  [NUM_SRC];
   bit m_irq;
   int m_max;
   int m_cid;

   typedef struct {
      bit                 irq;
      int                 max_id;
      int                 claim_id;
      logic [NUM_SRC-1:0] pend;
      logic [NUM_SRC-1:0] svc;
   } exp_t;

   exp_t sb_q[$];

   function automatic int pri_of(input int id);
      logic [NUM_SRC*PRI_W-1:0] p;
      p = pri;
      return int'(p[(id-1)*PRI_W +: PRI_W]);
   endfunction

   task automatic set_pri(input int id, input int val);
      pri[(id-1)*PRI_W +: PRI_W] = PRI_W'(val);
   endtask

   task automatic model_clear();
      for (int k = 0; k < NUM_SRC; k++) begin
         m_pend[k] = 0; m_svc[k] = 0; m_prev[k] = 0; m_cnt[k] = 0;
      end
      m_irq = 0; m_max = 0; m_cid = 0;
   endtask

   // Advance the model across one clock edge using the inputs currently
   // driven, queue the expected outputs, then wait for the next negedge.
   task automatic tick();
      exp_t e;
      bit   hit;
      int   best_id, best_pri, claimed;
      bit   np [NUM_SRC];
      bit   ns [NUM_SRC];

      hit     = claim && m_irq;
      claimed = hit ? m_max : 0;

      // Highest priority among eligible sources, lowest ID on ties. The
      // source claimed this cycle no longer competes.
      best_id = 0; best_pri = 0;
      for (int id = 1; id <= NUM_SRC; id++) begin
         if (m_pend[id-1] && src_en[id-1] && !m_svc[id-1] && id != claimed
             && pri_of(id) > best_pri) begin
            best_pri = pri_of(id);
            best_id  = id;
         end
      end

      if (claim) m_cid = claimed;

      for (int k = 0; k < NUM_SRC; k++) begin
         bit edg, req;
         edg   = interrupt[k] && !m_prev[k];
         req   = edge_mode[k] ? edg : interrupt[k];
         np[k] = m_pend[k];
         ns[k] = m_svc[k];
         if (claimed == k + 1) begin np[k] = 0; ns[k] = 1; end
         if (complete && int'(complete_id) == k + 1 && m_svc[k]) ns[k] = 0;
         if (req && !m_pend[k] && !m_svc[k]) np[k] = 1;
`ifdef PLIC_EDGE_QUEUE_EN
         if (edge_mode[k]) begin
            if (edg && (m_pend[k] || m_svc[k])) begin
               if (m_cnt[k] < 3) m_cnt[k]++;
            end else if (!m_pend[k] && !m_svc[k] && m_cnt[k] > 0) begin
               np[k] = 1;
               m_cnt[k]--;
            end
         end
`endif
      end
      for (int k = 0; k < NUM_SRC; k++) begin
         m_pend[k] = np[k];
         m_svc[k]  = ns[k];
         m_prev[k] = interrupt[k];
      end
      m_irq = global_en && (best_pri > int'(threshold));
      m_max = best_id;

      e.irq = m_irq; e.max_id = m_max; e.claim_id = m_cid;
      for (int k = 0; k < NUM_SRC; k++) begin
         e.pend[k] = m_pend[k];
         e.svc[k]  = m_svc[k];
      end
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // Asynchronous reset between clock edges; optionally checks that every
   // output drops immediately. Entered and left at a negedge.
   task automatic do_reset(input bit check);
      #2 rst_n = 1'b0;
      #1;
      if (check) begin
         chk("rst_irq", 32'(irq), 0);
         chk("rst_max_id", 32'(max_id), 0);
         chk("rst_claim_id", 32'(claim_id), 0);
         chk("rst_pending", 32'(pending), 0);
         chk("rst_in_service", 32'(in_service), 0);
      end
      model_clear();
      interrupt = '0; claim = 1'b0; complete = 1'b0; complete_id = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ------------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------------
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("sb_irq", 32'(irq), 32'(e.irq));
         chk("sb_max_id", 32'(max_id), e.max_id);
         chk("sb_claim_id", 32'(claim_id), e.claim_id);
         chk("sb_pending", 32'(pending), 32'(e.pend));
         chk("sb_in_service", 32'(in_service), 32'(e.svc));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      rst_n = 1'b0; interrupt = '0; src_en = '1; edge_mode = '0; pri = '0;
      threshold = '0; global_en = 1'b1; claim = 1'b0; complete = 1'b0;
      complete_id = '0;
      model_clear();
      #2;
      chk("init_irq", 32'(irq), 0);
      chk("init_max_id", 32'(max_id), 0);
      chk("init_pending", 32'(pending), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Level, single source ID3 pri 5 over threshold 2.
      threshold = 2; set_pri(3, 5);
      interrupt[2] = 1'b1;
      tick();
      chk("lvl_pend_T1", 32'(pending[2]), 1);
      chk("lvl_irq_T1", 32'(irq), 0);
      tick();
      chk("lvl_irq_T2", 32'(irq), 1);
      chk("lvl_max_T2", 32'(max_id), 3);
      claim = 1'b1; tick(); claim = 1'b0;
      chk("lvl_claim_id", 32'(claim_id), 3);
      chk("lvl_in_svc", 32'(in_service[2]), 1);
      chk("lvl_irq_after_claim", 32'(irq), 0);

      // Completes that must be ignored, then a valid one with line high.
      complete = 1'b1;
      complete_id = 0; tick();
      complete_id = 9; tick();
      complete_id = 4; tick();
      complete = 1'b0;
      chk("cmp_ignored_svc", 32'(in_service), 32'h04);
      complete = 1'b1; complete_id = 3; tick(); complete = 1'b0;
      chk("cmp_svc_cleared", 32'(in_service), 0);
      tick();
      chk("cmp_repend", 32'(pending[2]), 1);
      idle(2);

      // Priority and tie-break with back-to-back claims.
      do_reset(0);
      pri = '0; threshold = 2;
      set_pri(2, 4); set_pri(5, 7); set_pri(6, 7);
      interrupt = 8'b0011_0010;
      idle(2);
      chk("tie_max", 32'(max_id), 5);
      claim = 1'b1;
      tick();
      chk("tie_claim5", 32'(claim_id), 5);
      chk("tie_max6", 32'(max_id), 6);
      tick();
      claim = 1'b0;
      chk("tie_claim6", 32'(claim_id), 6);
      chk("tie_max2", 32'(max_id), 2);
      idle(2);

      // Threshold and global enable.
      do_reset(0);
      pri = '0; set_pri(1, 3); threshold = 3;
      interrupt[0] = 1'b1;
      idle(2);
      chk("thr_eq_irq", 32'(irq), 0);
      chk("thr_eq_max", 32'(max_id), 1);
      threshold = 2; tick();
      chk("thr_lt_irq", 32'(irq), 1);
      global_en = 1'b0; tick();
      chk("gen_off_irq", 32'(irq), 0);
      chk("gen_off_max", 32'(max_id), 1);
      claim = 1'b1; tick(); claim = 1'b0;
      chk("gen_off_claim", 32'(claim_id), 0);
      chk("gen_off_pend", 32'(pending[0]), 1);
      global_en = 1'b1;
      idle(2);

      // Edge source: three pulses while in service.
      do_reset(0);
      pri = '0; set_pri(1, 1); threshold = 0; edge_mode = 8'h01;
      interrupt[0] = 1'b1; tick(); interrupt[0] = 1'b0; tick(); tick();
      claim = 1'b1; tick(); claim = 1'b0;
      repeat (3) begin
         interrupt[0] = 1'b1; tick(); interrupt[0] = 1'b0; tick();
      end
      complete = 1'b1; complete_id = 1; tick(); complete = 1'b0;
      idle(3);
`ifdef PLIC_EDGE_QUEUE_EN
      chk("edge_requeued", 32'(pending[0]), 1);
`else
      chk("edge_dropped", 32'(pending[0]), 0);
`endif
      repeat (4) begin
         claim = 1'b1; tick(); claim = 1'b0;
         complete = 1'b1; complete_id = 1; tick(); complete = 1'b0;
         idle(3);
      end
      edge_mode = '0;

      // Async reset while requesting with sources in service.
      do_reset(0);
      pri = '0; set_pri(1, 2); set_pri(2, 5); set_pri(3, 6); set_pri(4, 3);
      threshold = 1;
      interrupt = 8'h0F;
      idle(2);
      claim = 1'b1; idle(2); claim = 1'b0;
      chk("pre_rst_irq", 32'(irq), 1);
      do_reset(1);
      idle(4);
      chk("post_rst_quiet", 32'(irq), 0);
      interrupt[0] = 1'b1;
      idle(3);
      chk("post_rst_refire", 32'(irq), 1);

      // Randomised traffic.
      do_reset(0);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0 || i == 0) begin
            for (int id = 1; id <= NUM_SRC; id++) set_pri(id, $urandom_range(0, 15));
            threshold = PRI_W'($urandom_range(0, 6));
            src_en    = NUM_SRC'($urandom | $urandom);
            edge_mode = NUM_SRC'($urandom);
            global_en = ($urandom_range(0, 7) != 0);
         end
         interrupt   = NUM_SRC'($urandom & $urandom);
         claim       = ($urandom_range(0, 3) == 0);
         complete    = ($urandom_range(0, 2) == 0);
         complete_id = ID_W'($urandom_range(0, 9));
         tick();
      end
      claim = 1'b0; complete = 1'b0; interrupt = '0;
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
